fetch_predict_stage: RTL
========================

Name: fetch_predict_stage

Overview:
- Fetch stage plus IF/ID pipeline register for the cached, branch-predicted ARM pipeline. Sits directly upstream of the instruction decoder.
- Holds the PC and drives the I-cache address.
- Predicts branches with a direct-mapped BTB that has 2-bit saturating counters, and redirects on mispredicts resolved in Execute.
- Registers InstrD/PCD/prediction into Decode.

Parameters:
- BTB_ENTRIES, 16: number of BTB entries (power of two).
- IDX_W, 4: log2(BTB_ENTRIES); index = PC[IDX_W+1:2].
- RESET_PC, 32'h0000_0000: PCF value after reset.

Ports:
- CLK  in  1  system clock, rising edge.
- Reset_n  in  1  asynchronous active-low reset.
- StallF  in  1  hold PCF.
- StallD  in  1  hold IF/ID register.
- FlushD  in  1  load bubble into IF/ID register.
- PCF  out  32  fetch address to I-cache.
- InstrF  in  32  instruction returned for PCF (same cycle).
- InstrD  out  32  registered instruction to decoder.
- PCD  out  32  registered PC of InstrD.
- ValidD  out  1  InstrD is a real instruction (0 = bubble).
- PredTakenD  out  1  prediction made for InstrD.
- PredTargetD  out  32  predicted target for InstrD.
- BrResolveE  in  1  branch/PC-writing instruction resolved in Execute this cycle.
- BrPCE  in  32  PC of resolving instruction.
- BrTakenE  in  1  actual direction.
- BrTargetE  in  32  actual target.
- PredTakenE  in  1  prediction carried down for that instruction.
- PredTargetE  in  32  predicted target carried down.
- MispredictE  out  1  combinational mispredict flag (hazard unit uses it to flush D and E).

Behaviour:
- Reset (async, Reset_n=0):
  - PCF=RESET_PC.
  - InstrD=0, PCD=0, ValidD=0, PredTakenD=0, PredTargetD=0.
  - All BTB valid bits=0; all counters=2'b01.
  - Reset mid-operation discards everything in flight; no BTB state survives.
- BTB entry fields: valid, tag = PC[31:IDX_W+2], target[31:0], ctr[1:0].
- Lookup (combinational on PCF):
  - hitF = valid && tag match at index PCF[IDX_W+1:2].
  - predTakenF = hitF && ctr[1].
  - predTargetF = entry target.
- MispredictE = BrResolveE && ((BrTakenE != PredTakenE) || (BrTakenE && BrTargetE != PredTargetE)).
- Next-PC priority, highest first:
  - MispredictE: PCF <= BrTakenE ? BrTargetE : BrPCE+4.
  - StallF: PCF holds.
  - predTakenF: PCF <= predTargetF.
  - otherwise: PCF <= PCF+4, 32-bit wrap (FFFF_FFFC -> 0000_0000).
- IF/ID register priority, highest first:
  - FlushD: InstrD=0, ValidD=0, PredTakenD=0, PredTargetD=0; PCD=PCF.
  - StallD: hold all fields.
  - otherwise: InstrD=InstrF, PCD=PCF, ValidD=1, PredTakenD=predTakenF, PredTargetD=predTargetF.
  - FlushD and StallD together: flush wins.
- BTB update (clock edge, when BrResolveE=1), index/tag from BrPCE:
  - Taken and hit: ctr saturating increment (max 2'b11); target <= BrTargetE.
  - Taken and miss: allocate/overwrite entry with valid=1, new tag, target=BrTargetE, ctr=2'b10.
  - Not taken and hit: ctr saturating decrement (min 2'b00); entry stays valid.
  - Not taken and miss: no change.
- Update/lookup collision (same index in the same cycle): lookup sees the pre-update contents. There is no bypass.
- Update proceeds regardless of StallF/StallD/FlushD.
- Aliasing: a different tag at the same index is a miss. A taken allocation evicts the previous entry.
- Latency:
  - Prediction: zero cycles; PCF redirects on the next edge.
  - Mispredict redirect: next edge after MispredictE.
  - InstrD: one cycle after PCF.

Test Plan:
- Reset then release, no branches -> PCF sequence 0,4,8,C; InstrD/PCD lag one cycle; ValidD=1 from the second cycle.
- StallF=StallD=1 for 3 cycles at PCF=0x10 -> PCF, InstrD, PCD frozen; releasing resumes at 0x14. FlushD=1 with StallD=1 -> ValidD=0, InstrD=0.
- Resolve BrPCE=0x20, taken, target 0x100, PredTakenE=0 -> MispredictE=1; PCF=0x100 next cycle; entry 8 allocated with ctr=10. The next fetch of 0x20 goes to 0x100 with PredTakenD=1.
- Repeated taken resolutions of 0x20 saturate ctr at 11. Two not-taken resolutions bring ctr to 01 -> fetch of 0x20 predicts 0x24. A third and fourth not-taken resolution leave ctr at 00.
- Predicted taken to 0x100 but actual target 0x200 -> MispredictE=1; PCF=0x200; BTB target updated to 0x200.
- Alias: 0x20 and 0x60 (same index, IDX_W=4). A taken resolution of 0x60 evicts 0x20 -> fetch of 0x20 misses and predicts 0x24. Update and lookup of the same index in one cycle -> lookup returns the old entry.

Source files
------------

// File: rtl/fetch_predict_stage.sv
// Fetch stage with a direct-mapped BTB (2-bit counters) and the IF/ID pipeline register.
// Mispredicts resolved in Execute redirect PCF on the following edge.
module fetch_predict_stage #(
    parameter int          BTB_ENTRIES = 16,
    parameter int          IDX_W       = 4,
    parameter logic [31:0] RESET_PC    = 32'h0000_0000
) (
    input  logic        CLK,
    input  logic        Reset_n,
    input  logic        StallF,
    input  logic        StallD,
    input  logic        FlushD,
    output logic [31:0] PCF,
    input  logic [31:0] InstrF,
    output logic [31:0] InstrD,
    output logic [31:0] PCD,
    output logic        ValidD,
    output logic        PredTakenD,
    output logic [31:0] PredTargetD,
    input  logic        BrResolveE,
    input  logic [31:0] BrPCE,
    input  logic        BrTakenE,
    input  logic [31:0] BrTargetE,
    input  logic        PredTakenE,
    input  logic [31:0] PredTargetE,
    output logic        MispredictE
);

    localparam int TAG_W = 32 - IDX_W - 2;

    logic             r_btbValid  [BTB_ENTRIES];
    logic [TAG_W-1:0] r_btbTag    [BTB_ENTRIES];
    logic [31:0]      r_btbTarget [BTB_ENTRIES];
    logic [1:0]       r_btbCtr    [BTB_ENTRIES];

    logic [31:0] r_pcF;
    logic [31:0] r_instrD;
    logic [31:0] r_pcD;
    logic        r_validD;
    logic        r_predTakenD;
    logic [31:0] r_predTargetD;

    logic [IDX_W-1:0] w_idxF;
    logic [TAG_W-1:0] w_tagF;
    logic             w_hitF;
    logic             w_predTakenF;
    logic [31:0]      w_predTargetF;
    logic [IDX_W-1:0] w_idxE;
    logic [TAG_W-1:0] w_tagE;
    logic             w_hitE;
    logic [1:0]       w_ctrE;
    logic [1:0]       w_ctrInc;
    logic [1:0]       w_ctrDec;
    logic             w_mispredict;
    logic [31:0]      w_nextPc;

    // Lookup reads the array state before this edge's update, so there is no bypass.
    assign w_idxF        = r_pcF[IDX_W+1:2];
    assign w_tagF        = r_pcF[31:IDX_W+2];
    assign w_hitF        = r_btbValid[w_idxF] && (r_btbTag[w_idxF] == w_tagF);
    assign w_predTakenF  = w_hitF && r_btbCtr[w_idxF][1];
    assign w_predTargetF = r_btbTarget[w_idxF];

    assign w_idxE   = BrPCE[IDX_W+1:2];
    assign w_tagE   = BrPCE[31:IDX_W+2];
    assign w_hitE   = r_btbValid[w_idxE] && (r_btbTag[w_idxE] == w_tagE);
    assign w_ctrE   = r_btbCtr[w_idxE];
    assign w_ctrInc = (w_ctrE == 2'b11) ? 2'b11 : w_ctrE + 2'b01;
    assign w_ctrDec = (w_ctrE == 2'b00) ? 2'b00 : w_ctrE - 2'b01;

    assign w_mispredict = BrResolveE &&
                          ((BrTakenE != PredTakenE) ||
                           (BrTakenE && (BrTargetE != PredTargetE)));

    always_comb begin
        w_nextPc = r_pcF + 32'd4;
        if (w_mispredict) begin
            w_nextPc = BrTakenE ? BrTargetE : BrPCE + 32'd4;
        end else if (StallF) begin
            w_nextPc = r_pcF;
        end else if (w_predTakenF) begin
            w_nextPc = w_predTargetF;
        end
    end

    always_ff @(posedge CLK or negedge Reset_n) begin
        if (!Reset_n) begin
            r_pcF <= RESET_PC;
        end else begin
            r_pcF <= w_nextPc;
        end
    end

    // Flush takes precedence over stall; a bubble still records the PC it replaced.
    always_ff @(posedge CLK or negedge Reset_n) begin
        if (!Reset_n) begin
            r_instrD      <= '0;
            r_pcD         <= '0;
            r_validD      <= 1'b0;
            r_predTakenD  <= 1'b0;
            r_predTargetD <= '0;
        end else if (FlushD) begin
            r_instrD      <= '0;
            r_pcD         <= r_pcF;
            r_validD      <= 1'b0;
            r_predTakenD  <= 1'b0;
            r_predTargetD <= '0;
        end else if (!StallD) begin
            r_instrD      <= InstrF;
            r_pcD         <= r_pcF;
            r_validD      <= 1'b1;
            r_predTakenD  <= w_predTakenF;
            r_predTargetD <= w_predTargetF;
        end
    end

    // Training ignores pipeline stalls/flushes; a taken miss evicts whatever shares the index.
    always_ff @(posedge CLK or negedge Reset_n) begin
        if (!Reset_n) begin
            for (int i = 0; i < BTB_ENTRIES; i++) begin
                r_btbValid[i]  <= 1'b0;
                r_btbTag[i]    <= '0;
                r_btbTarget[i] <= '0;
                r_btbCtr[i]    <= 2'b01;
            end
        end else if (BrResolveE) begin
            if (BrTakenE) begin
                if (w_hitE) begin
                    r_btbCtr[w_idxE]    <= w_ctrInc;
                    r_btbTarget[w_idxE] <= BrTargetE;
                end else begin
                    r_btbValid[w_idxE]  <= 1'b1;
                    r_btbTag[w_idxE]    <= w_tagE;
                    r_btbTarget[w_idxE] <= BrTargetE;
                    r_btbCtr[w_idxE]    <= 2'b10;
                end
            end else if (w_hitE) begin
                r_btbCtr[w_idxE] <= w_ctrDec;
            end
        end
    end

    assign PCF         = r_pcF;
    assign InstrD      = r_instrD;
    assign PCD         = r_pcD;
    assign ValidD      = r_validD;
    assign PredTakenD  = r_predTakenD;
    assign PredTargetD = r_predTargetD;
    assign MispredictE = w_mispredict;

endmodule
